// File: rtl/input_cond_pkg.sv
// Shared definitions for the arcade input conditioner.
//   - Bit positions of the merged player controls.
//   - Coin shaper FSM state type.
//   - Default timing values for a 40 MHz system clock.
//   - SOCD resolution helper for one axis.
package input_cond_pkg;

  localparam int unsigned NUM_BTN    = 8;
  localparam int unsigned BTN_R      = 0;
  localparam int unsigned BTN_L      = 1;
  localparam int unsigned BTN_D      = 2;
  localparam int unsigned BTN_U      = 3;
  localparam int unsigned BTN_FIRE   = 4;
  localparam int unsigned BTN_START1 = 5;
  localparam int unsigned BTN_START2 = 6;
  localparam int unsigned BTN_COIN   = 7;

  localparam int unsigned DEF_DB_CYCLES  = 40000;     // 1 ms
  localparam int unsigned DEF_COIN_PULSE = 2000000;   // 50 ms
  localparam int unsigned DEF_COIN_GAP   = 4000000;   // 100 ms
  localparam int unsigned DEF_COMBO_HOLD = 20000000;  // 0.5 s

  localparam int unsigned DB_CNT_W    = 16;
  localparam int unsigned COIN_CNT_W  = 23;
  localparam int unsigned COMBO_CNT_W = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  // pressed[0] is the first direction of the axis (R or D), pressed[1] the opposite one.
  // last_hi = 1 means pressed[1] had the most recent rising edge.
  function automatic logic [1:0] socd_resolve(input logic [1:0] pressed,
                                              input logic       mode,
                                              input logic       last_hi);
    logic [1:0] res;
    res = pressed;
    if (pressed == 2'b11) begin
      if (!mode)        res = 2'b00;
      else if (last_hi) res = 2'b10;
      else              res = 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button synchroniser and debouncer.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   raw_i   : raw asynchronous button level
//   deb_o   : debounced level (changes after DbCycles stable synchronised cycles)
//   rise_o  : one-cycle strobe, high in the first cycle deb_o reads 1
module btn_debounce
  import input_cond_pkg::*;
#(
  parameter int unsigned DbCycles = DEF_DB_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic deb_o,
  output logic rise_o
);

  logic [1:0]          sync_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                deb_q, deb_d;
  logic                rise_q, rise_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == DB_CNT_W'(DbCycles - 1)) begin
        deb_d = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
    rise_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
    end
  end

  assign deb_o  = deb_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/arcade_input_conditioner.sv
// Conditions merged player controls for the berzerk core.
//   clk_sys   : 40 MHz system clock
//   reset_n   : asynchronous active-low reset (released synchronously inside)
//   in_raw    : raw buttons {coin, start2, start1, fire, U, D, L, R}
//   socd_mode : 0 = opposing directions cancel, 1 = last pressed wins
//   combo_en  : enables the Start1+Fire coin combo
//   out_btn   : conditioned buttons, bit 7 is the shaped coin pulse
//   coin_busy : coin shaper not idle
//   coin_drop : one-cycle strobe when a coin request is discarded
module arcade_input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned COIN_PULSE = DEF_COIN_PULSE,
  parameter int unsigned COIN_GAP   = DEF_COIN_GAP,
  parameter int unsigned COMBO_HOLD = DEF_COMBO_HOLD
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [NUM_BTN-1:0]   in_raw,
  input  logic                 socd_mode,
  input  logic                 combo_en,
  output logic [NUM_BTN-1:0]   out_btn,
  output logic                 coin_busy,
  output logic                 coin_drop
);

  // Reset: asserts asynchronously, releases two clocks after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] rise;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(
      .DbCycles(DB_CYCLES)
    ) u_btn_debounce (
      .clk_i  (clk_sys),
      .rst_ni (rst_n),
      .raw_i  (in_raw[i]),
      .deb_o  (deb[i]),
      .rise_o (rise[i])
    );
  end

  logic unused_sig;
  assign unused_sig = ^{rise[BTN_START2:BTN_FIRE], deb[BTN_COIN]};

  // SOCD: remember which side of each axis rose last. A same-cycle tie keeps the old owner.
  logic       last_h_q, last_h_d;
  logic       last_v_q, last_v_d;
  logic [6:0] btn_q, btn_d;

  always_comb begin
    last_h_d = last_h_q;
    if (rise[BTN_R] && !rise[BTN_L])      last_h_d = 1'b0;
    else if (rise[BTN_L] && !rise[BTN_R]) last_h_d = 1'b1;

    last_v_d = last_v_q;
    if (rise[BTN_D] && !rise[BTN_U])      last_v_d = 1'b0;
    else if (rise[BTN_U] && !rise[BTN_D]) last_v_d = 1'b1;

    // Use the next-state memory so a fresh press wins in the same cycle it appears.
    btn_d = {deb[BTN_START2], deb[BTN_START1], deb[BTN_FIRE],
             socd_resolve(deb[BTN_U:BTN_D], socd_mode, last_v_d),
             socd_resolve(deb[BTN_L:BTN_R], socd_mode, last_h_d)};
  end

  // Start1+Fire combo: one request per hold, counter parks at its terminal value.
  logic                   combo_active;
  logic                   combo_fire;
  logic [COMBO_CNT_W-1:0] combo_cnt_q, combo_cnt_d;
  logic                   combo_done_q, combo_done_d;

  assign combo_active = combo_en & deb[BTN_START1] & deb[BTN_FIRE];

  always_comb begin
    combo_cnt_d  = '0;
    combo_done_d = 1'b0;
    combo_fire   = 1'b0;
    if (combo_active) begin
      combo_cnt_d  = combo_cnt_q;
      combo_done_d = combo_done_q;
      if (combo_cnt_q != COMBO_CNT_W'(COMBO_HOLD - 1)) begin
        combo_cnt_d = combo_cnt_q + COMBO_CNT_W'(1);
      end else if (!combo_done_q) begin
        combo_fire   = 1'b1;
        combo_done_d = 1'b1;
      end
    end
  end

  // Coin shaper with a single pending slot.
  logic                  coin_req;
  coin_state_t           state_q, state_d;
  logic [COIN_CNT_W-1:0] coin_cnt_q, coin_cnt_d;
  logic                  pending_q, pending_d;
  logic                  drop_q, drop_d;

  assign coin_req = rise[BTN_COIN] | combo_fire;

  always_comb begin
    state_d    = state_q;
    coin_cnt_d = coin_cnt_q;
    pending_d  = pending_q;
    drop_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (coin_req || pending_q) begin
          state_d    = PULSE;
          coin_cnt_d = '0;
          // A fresh request landing while the slot is consumed refills it.
          pending_d  = pending_q & coin_req;
        end
      end
      PULSE: begin
        if (coin_cnt_q == COIN_CNT_W'(COIN_PULSE - 1)) begin
          state_d    = GAP;
          coin_cnt_d = '0;
        end else begin
          coin_cnt_d = coin_cnt_q + COIN_CNT_W'(1);
        end
      end
      GAP: begin
        if (coin_cnt_q == COIN_CNT_W'(COIN_GAP - 1)) begin
          state_d    = IDLE;
          coin_cnt_d = '0;
        end else begin
          coin_cnt_d = coin_cnt_q + COIN_CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        coin_cnt_d = '0;
      end
    endcase

    if (state_q != IDLE && coin_req) begin
      if (!pending_q) pending_d = 1'b1;
      else            drop_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      last_h_q     <= 1'b0;
      last_v_q     <= 1'b0;
      btn_q        <= '0;
      combo_cnt_q  <= '0;
      combo_done_q <= 1'b0;
      state_q      <= IDLE;
      coin_cnt_q   <= '0;
      pending_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      last_h_q     <= last_h_d;
      last_v_q     <= last_v_d;
      btn_q        <= btn_d;
      combo_cnt_q  <= combo_cnt_d;
      combo_done_q <= combo_done_d;
      state_q      <= state_d;
      coin_cnt_q   <= coin_cnt_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
    end
  end

  assign out_btn   = {(state_q == PULSE), btn_q};
  assign coin_busy = (state_q != IDLE);
  assign coin_drop = drop_q;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
module tb_arcade_input_conditioner;

  localparam int unsigned DB    = 4;
  localparam int unsigned PW    = 8;
  localparam int unsigned GW    = 6;
  localparam int unsigned HOLD  = 10;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_raw = 8'h00;
  logic       socd_mode = 1'b0;
  logic       combo_en = 1'b0;
  logic [7:0] out_btn;
  logic       coin_busy;
  logic       coin_drop;

  int n_vec = 0;
  int n_err = 0;

  arcade_input_conditioner #(
    .DB_CYCLES  (DB),
    .COIN_PULSE (PW),
    .COIN_GAP   (GW),
    .COMBO_HOLD (HOLD)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .in_raw    (in_raw),
    .socd_mode (socd_mode),
    .combo_en  (combo_en),
    .out_btn   (out_btn),
    .coin_busy (coin_busy),
    .coin_drop (coin_drop)
  );

  always #5 clk_sys = ~clk_sys;

  // Coin output monitor: counts pulses and drop strobes, records run lengths.
  int   mon_rises = 0;
  int   mon_drops = 0;
  int   mon_run = 0;
  int   mon_last_low = 0;
  int   mon_last_high = 0;
  logic mon_prev = 1'b0;

  always @(negedge clk_sys) begin
    if (coin_drop) mon_drops <= mon_drops + 1;
    if (out_btn[7] == mon_prev) begin
      mon_run <= mon_run + 1;
    end else begin
      if (out_btn[7]) begin
        mon_rises    <= mon_rises + 1;
        mon_last_low <= mon_run;
      end else begin
        mon_last_high <= mon_run;
      end
      mon_run <= 1;
    end
    mon_prev <= out_btn[7];
  end

  typedef struct {
    logic [7:0] raw;
    logic       mode;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_coin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk_sys);
      ok = out_btn[7];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   ok;
    logic seen;
    logic samp [1:8];
    int   r0, d0, hi, busy_bad, gap;

    tbl[0]  = '{8'h00, 1'b0, 7'h00};
    tbl[1]  = '{8'h01, 1'b0, 7'h01};
    tbl[2]  = '{8'h03, 1'b0, 7'h00};
    tbl[3]  = '{8'h02, 1'b0, 7'h02};
    tbl[4]  = '{8'h00, 1'b0, 7'h00};
    tbl[5]  = '{8'h01, 1'b1, 7'h01};
    tbl[6]  = '{8'h03, 1'b1, 7'h02};
    tbl[7]  = '{8'h01, 1'b1, 7'h01};
    tbl[8]  = '{8'h03, 1'b1, 7'h02};
    tbl[9]  = '{8'h02, 1'b1, 7'h02};
    tbl[10] = '{8'h03, 1'b1, 7'h01};
    tbl[11] = '{8'h0F, 1'b1, 7'h05};
    tbl[12] = '{8'h07, 1'b1, 7'h05};
    tbl[13] = '{8'h0F, 1'b1, 7'h09};
    tbl[14] = '{8'h0F, 1'b0, 7'h00};
    tbl[15] = '{8'h70, 1'b0, 7'h70};
    tbl[16] = '{8'h7F, 1'b0, 7'h70};
    tbl[17] = '{8'h00, 1'b0, 7'h00};

    // Reset state
    step(3);
    @(negedge clk_sys);
    check("rst_out_btn", 32'(out_btn), 32'h0);
    check("rst_coin_busy", 32'(coin_busy), 32'h0);
    check("rst_coin_drop", 32'(coin_drop), 32'h0);
    reset_n = 1'b1;
    step(4);

    // 3-cycle glitch on fire must be filtered
    in_raw[4] = 1'b1;
    step(3);
    in_raw[4] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk_sys);
      seen = seen | out_btn[4];
    end
    check("fire_glitch", 32'(seen), 32'h0);

    // Held fire appears exactly 7 cycles after the raw edge
    step(1);
    in_raw[4] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      samp[k] = out_btn[4];
    end
    check("fire_lat_6", 32'(samp[6]), 32'h0);
    check("fire_lat_7", 32'(samp[7]), 32'h1);
    in_raw[4] = 1'b0;
    step(12);

    // SOCD and pass-through vectors
    for (int i = 0; i < 18; i++) begin
      in_raw    = tbl[i].raw;
      socd_mode = tbl[i].mode;
      step(10);
      @(negedge clk_sys);
      check($sformatf("vec%0d", i), 32'(out_btn), {25'd0, tbl[i].exp});
    end
    step(1);
    check("no_coin_combo_off", 32'(mon_rises), 32'h0);

    // Single coin press: 8 high, 6 gap cycles busy, then idle
    socd_mode = 1'b0;
    in_raw[7] = 1'b1;
    step(5);
    in_raw[7] = 1'b0;
    wait_coin(ok);
    check("coin_seen", 32'(ok), 32'h1);
    hi = 0;
    busy_bad = 0;
    while (out_btn[7] && hi < 40) begin
      hi++;
      if (!coin_busy) busy_bad++;
      @(negedge clk_sys);
    end
    gap = 0;
    while (!out_btn[7] && coin_busy && gap < 40) begin
      gap++;
      @(negedge clk_sys);
    end
    check("coin_high_len", 32'(hi), 32'(PW));
    check("coin_busy_pulse", 32'(busy_bad), 32'h0);
    check("coin_gap_len", 32'(gap), 32'(GW));
    check("coin_idle_busy", 32'(coin_busy), 32'h0);
    step(10);

    // Three requests while busy: coin, second coin (pending), combo (dropped)
    combo_en = 1'b1;
    r0 = mon_rises;
    d0 = mon_drops;
    in_raw[7] = 1'b1;
    step(3);
    in_raw[5:4] = 2'b11;
    step(1);
    in_raw[7] = 1'b0;
    step(4);
    in_raw[7] = 1'b1;
    step(4);
    in_raw[7] = 1'b0;
    step(60);
    check("multi_pulses", 32'(mon_rises - r0), 32'd2);
    check("multi_drops", 32'(mon_drops - d0), 32'd1);
    check("multi_gap_low", 32'(mon_last_low), 32'(GW + 1));
    check("multi_2nd_high", 32'(mon_last_high), 32'(PW));
    in_raw = 8'h00;
    step(20);

    // Combo enabled: exactly one pulse for a long hold
    r0 = mon_rises;
    d0 = mon_drops;
    in_raw[5:4] = 2'b11;
    step(30);
    in_raw = 8'h00;
    step(30);
    check("combo_one_pulse", 32'(mon_rises - r0), 32'd1);
    check("combo_no_drop", 32'(mon_drops - d0), 32'd0);

    // Combo disabled: no pulse
    combo_en = 1'b0;
    r0 = mon_rises;
    in_raw[5:4] = 2'b11;
    step(30);
    in_raw = 8'h00;
    step(20);
    check("combo_off_none", 32'(mon_rises - r0), 32'd0);

    // Reset mid-pulse clears the coin output at once
    in_raw[7] = 1'b1;
    step(5);
    in_raw[7] = 1'b0;
    wait_coin(ok);
    check("rst_mid_seen", 32'(ok), 32'h1);
    step(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_out", 32'(out_btn), 32'h0);
    check("rst_mid_busy", 32'(coin_busy), 32'h0);
    step(3);
    reset_n = 1'b1;
    r0 = mon_rises;
    step(30);
    check("rst_no_pulse", 32'(mon_rises - r0), 32'd0);
    @(negedge clk_sys);
    check("rst_final_out", 32'(out_btn), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
